// File: rtl/tag_responder_if.sv
// Command/response handshake between the AFU tag issuer (master) and the tag responder (slave).
interface tag_responder_if #(
   parameter int unsigned TAG_WIDTH = 8
);
   logic                 command_valid;
   logic [TAG_WIDTH-1:0] command_tag;
   logic                 command_ready;
   logic                 response_ready;
   logic                 response_valid;
   logic [TAG_WIDTH-1:0] response_tag;

   modport master (
      output command_valid, command_tag, response_ready,
      input  command_ready, response_valid, response_tag
   );

   modport slave (
      input  command_valid, command_tag, response_ready,
      output command_ready, response_valid, response_tag
   );
endinterface

// File: rtl/tag_responder.sv
// PSL stand-in for the AFU tag pool: accepts tagged commands, holds each for a minimum latency,
// then returns them in issue order; flags re-issue of a tag that is still outstanding.
module tag_responder #(
   parameter int unsigned TAG_COUNT = 256,
   parameter int unsigned TAG_WIDTH = 8,
   parameter int unsigned LATENCY   = 16,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enabled_in,
   tag_responder_if.slave     bus,
   output logic [TAG_WIDTH:0] outstanding_count,
   output logic               error_dup_tag
);
   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   // Head is ripe for the next cycle once its current age reaches LATENCY-1.
   localparam logic [CNT_WIDTH-1:0] RipeAge  = CNT_WIDTH'(LATENCY - 1);
   localparam logic [TAG_WIDTH:0]   FullCount = (TAG_WIDTH + 1)'(TAG_COUNT);
   localparam logic [TAG_WIDTH:0]   OneCount  = (TAG_WIDTH + 1)'(1);

   state_e               state_q, state_d;
   logic                 enabled_q;
   logic [CNT_WIDTH-1:0] stamp_q;
   logic [TAG_WIDTH-1:0] tag_mem_q   [TAG_COUNT];
   logic [CNT_WIDTH-1:0] stamp_mem_q [TAG_COUNT];
   logic [TAG_WIDTH-1:0] wr_ptr_q, rd_ptr_q, rd_next;
   logic [TAG_WIDTH:0]   count_q, count_d;
   logic [TAG_COUNT-1:0] live_q, live_d;
   logic                 error_q, error_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [TAG_WIDTH-1:0] resp_tag_q, resp_tag_d;

   logic                 accept, pop, dup, push;
   logic                 head_exists;
   logic [TAG_WIDTH-1:0] head_tag;
   logic [CNT_WIDTH-1:0] head_stamp, head_age;

   assign bus.command_ready  = (state_q == StRun) && (count_q < FullCount);
   assign bus.response_valid = resp_valid_q;
   assign bus.response_tag   = resp_tag_q;
   assign outstanding_count  = count_q;
   assign error_dup_tag      = error_q;

   assign accept  = bus.command_valid && bus.command_ready;
   assign pop     = resp_valid_q && bus.response_ready;
   // A tag being returned this cycle may legally be re-issued in the same cycle.
   assign dup     = accept && live_q[bus.command_tag]
                    && !(pop && (resp_tag_q == bus.command_tag));
   assign push    = accept && !dup;
   assign rd_next = rd_ptr_q + TAG_WIDTH'(1);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (enabled_q) state_d = StRun;
         StRun:   if (!enabled_q) state_d = StDrain;
         StDrain: begin
            if (enabled_q) begin
               state_d = StRun;
            end else if (count_q == '0) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Entry that will sit at the queue head next cycle, including a bypassed fresh push.
   always_comb begin
      head_exists = 1'b0;
      head_tag    = bus.command_tag;
      head_stamp  = stamp_q;
      if (pop) begin
         if (count_q > OneCount) begin
            head_exists = 1'b1;
            head_tag    = tag_mem_q[rd_next];
            head_stamp  = stamp_mem_q[rd_next];
         end else if (push) begin
            head_exists = 1'b1;
         end
      end else if (count_q != '0) begin
         head_exists = 1'b1;
         head_tag    = tag_mem_q[rd_ptr_q];
         head_stamp  = stamp_mem_q[rd_ptr_q];
      end else if (push) begin
         head_exists = 1'b1;
      end
   end

   assign head_age = stamp_q - head_stamp;

   // A presented response is held until taken, so a stalled head never un-ripens.
   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_tag_d   = resp_tag_q;
      if (pop || !resp_valid_q) begin
         resp_valid_d = head_exists && (head_age >= RipeAge) && (state_d != StIdle);
         if (resp_valid_d) begin
            resp_tag_d = head_tag;
         end
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + OneCount;
      end else if (pop && !push) begin
         count_d = count_q - OneCount;
      end
   end

   always_comb begin
      live_d  = live_q;
      error_d = error_q || dup;
      if (pop) begin
         live_d[resp_tag_q] = 1'b0;
      end
      if (push) begin
         live_d[bus.command_tag] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         enabled_q    <= 1'b0;
         stamp_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         live_q       <= '0;
         error_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_tag_q   <= '0;
      end else begin
         state_q      <= state_d;
         enabled_q    <= enabled_in;
         stamp_q      <= stamp_q + CNT_WIDTH'(1);
         count_q      <= count_d;
         live_q       <= live_d;
         error_q      <= error_d;
         resp_valid_q <= resp_valid_d;
         resp_tag_q   <= resp_tag_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + TAG_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_next;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         tag_mem_q[wr_ptr_q]   <= bus.command_tag;
         stamp_mem_q[wr_ptr_q] <= stamp_q;
      end
   end
endmodule
